// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the dual-clock FIFO (rclk domain).
// Pops FIFO words into a 2-entry skid buffer and presents them as a
// valid/ready stream. The block also provides enable/flush control and
// counters for delivered and flushed words.
module fifo_rd_stream #(
   parameter int Dsize = 8,
   parameter int CNT_W = 16
) (
   input  logic             rclk,
   input  logic             r_rst,
   input  logic [Dsize-1:0] rd_data,
   input  logic             rempty,
   output logic             rinc,
   input  logic             en,
   input  logic             flush,
   output logic [Dsize-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic [CNT_W-1:0] out_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t           state;
   logic [1:0]       occ;
   logic [1:0]       occ_next;
   logic [Dsize-1:0] buf1;
   logic             push;
   logic             pop;

   // Pop strobe and skid-buffer bookkeeping; m_ready never reaches rinc.
   // en gates rinc directly so fetching stops in the cycle en drops.
   always_comb begin
      rinc     = 1'b0;
      push     = 1'b0;
      pop      = m_valid && m_ready;
      occ_next = occ;
      case (state)
         RUN:     rinc = en && !rempty && (occ != 2'd2);
         FLUSH:   rinc = !rempty;
         default: rinc = 1'b0;
      endcase
      push = rinc && (state != FLUSH);
      if (push && !pop)
         occ_next = occ + 2'd1;
      else if (!push && pop)
         occ_next = occ - 2'd1;
   end

   // Control FSM, skid-buffer storage and word counters.
   always_ff @(posedge rclk or posedge r_rst) begin
      if (r_rst) begin
         state     <= IDLE;
         occ       <= 2'd0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         buf1      <= '0;
         busy      <= 1'b0;
         out_cnt   <= '0;
         flush_cnt <= '0;
      end else begin
         out_cnt <= out_cnt + CNT_W'(pop);

         // m_data is the oldest entry; buf1 holds the second one.
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0)
                  m_data <= rd_data;
               else
                  buf1 <= rd_data;
            end
            2'b01:   m_data <= buf1;
            2'b11:   m_data <= rd_data;
            default: m_data <= m_data;
         endcase

         case (state)
            IDLE, RUN: begin
               if (flush) begin
                  // Whatever stays buffered after this edge's transfer is discarded.
                  state     <= FLUSH;
                  busy      <= 1'b1;
                  occ       <= 2'd0;
                  m_valid   <= 1'b0;
                  flush_cnt <= flush_cnt + CNT_W'(occ_next);
               end else begin
                  state   <= en ? RUN : IDLE;
                  occ     <= occ_next;
                  m_valid <= (occ_next != 2'd0);
               end
            end
            FLUSH: begin
               if (rempty) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               occ     <= 2'd0;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream with a queue-based FIFO model.
module tb_fifo_rd_stream;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   logic          rclk = 1'b0;
   logic          r_rst;
   logic [DW-1:0] rd_data;
   logic          rempty;
   logic          rinc;
   logic          en;
   logic          flush;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] flush_cnt;

   fifo_rd_stream #(.Dsize(DW), .CNT_W(CW)) dut (
      .rclk(rclk), .r_rst(r_rst), .rd_data(rd_data), .rempty(rempty), .rinc(rinc),
      .en(en), .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .out_cnt(out_cnt), .flush_cnt(flush_cnt)
   );

   always #5 rclk = ~rclk;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sb[$];
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int first_xfer = -1;
   int last_xfer = -1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic load(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(base + DW'(i));
         sb.push_back(base + DW'(i));
      end
   endtask

   // One rclk cycle: present FIFO head, check output, apply the pop after the edge.
   task automatic step();
      logic          rinc_s;
      logic [DW-1:0] exp;
      rempty  = (fifo_q.size() == 0);
      rd_data = rempty ? '0 : fifo_q[0];
      #1;
      rinc_s = rinc;
      if (rempty) check_eq("no_pop_empty", 32'(rinc), 32'd0);
      if (m_valid && m_ready) begin
         if (sb.size() == 0) begin
            check_eq("extra_word", 32'(m_valid), 32'd0);
         end else begin
            exp = sb.pop_front();
            check_eq("m_data", 32'(m_data), 32'(exp));
         end
         if (first_xfer < 0) first_xfer = cyc;
         last_xfer = cyc;
      end
      @(posedge rclk);
      #1;
      cyc++;
      if (rinc_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((sb.size() != 0 || fifo_q.size() != 0) && k < 60) begin
         step();
         k++;
      end
      check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
      repeat (2) step();
   endtask

   initial begin
      logic [DW-1:0] held;
      int k;
      r_rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
      rempty = 1'b1; rd_data = '0;
      #12;
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_rinc", 32'(rinc), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_out_cnt", 32'(out_cnt), 32'd0);
      check_eq("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      @(posedge rclk); #1;
      r_rst = 1'b0;

      // 1: three words stream out on consecutive cycles
      en = 1'b1; m_ready = 1'b1;
      load(8'hA1, 3);
      first_xfer = -1;
      drain("t1");
      check_eq("t1_back_to_back", 32'(last_xfer - first_xfer), 32'd2);
      check_eq("t1_out_cnt", 32'(out_cnt), 32'd3);
      check_eq("t1_rinc_idle", 32'(rinc), 32'd0);

      // 2: backpressure fills the skid buffer then stops popping
      m_ready = 1'b0;
      load(8'hB0, 5);
      repeat (6) step();
      check_eq("t2_fifo_left", 32'(fifo_q.size()), 32'd3);
      check_eq("t2_rinc_full", 32'(rinc), 32'd0);
      check_eq("t2_valid", 32'(m_valid), 32'd1);
      held = sb[0];
      check_eq("t2_head", 32'(m_data), 32'(held));
      repeat (2) step();
      check_eq("t2_head_stable", 32'(m_data), 32'(held));
      m_ready = 1'b1;
      drain("t2");
      check_eq("t2_out_cnt", 32'(out_cnt), 32'd8);

      // 3: flush with two buffered and three still in the FIFO
      m_ready = 1'b0;
      load(8'hC0, 5);
      repeat (6) step();
      check_eq("t3_fifo_left", 32'(fifo_q.size()), 32'd3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      sb.delete();
      check_eq("t3_busy", 32'(busy), 32'd1);
      check_eq("t3_valid_off", 32'(m_valid), 32'd0);
      check_eq("t3_flush_entry", 32'(flush_cnt), 32'd2);
      k = 0;
      while (busy && k < 20) begin
         step();
         k++;
      end
      check_eq("t3_busy_cycles", 32'(k), 32'd4);
      check_eq("t3_fifo_empty", 32'(fifo_q.size()), 32'd0);
      check_eq("t3_flush_cnt", 32'(flush_cnt), 32'd5);
      check_eq("t3_out_cnt", 32'(out_cnt), 32'd8);
      check_eq("t3_valid_after", 32'(m_valid), 32'd0);
      repeat (2) step();

      // 4: en drops while the FIFO still holds words
      m_ready = 1'b1;
      load(8'hD0, 4);
      step();
      en = 1'b0;
      #1;
      check_eq("t4_rinc_same_cycle", 32'(rinc), 32'd0);
      repeat (4) step();
      check_eq("t4_fifo_held", 32'(fifo_q.size()), 32'd3);
      check_eq("t4_delivered", 32'(sb.size()), 32'd3);
      en = 1'b1;
      drain("t4");
      check_eq("t4_out_cnt", 32'(out_cnt), 32'd12);

      // 5: asynchronous reset in the middle of a stream
      load(8'hE0, 6);
      repeat (3) step();
      check_eq("t5_pre_rinc", 32'(rinc), 32'd1);
      check_eq("t5_pre_valid", 32'(m_valid), 32'd1);
      #2;
      r_rst = 1'b1;
      #1;
      check_eq("t5_valid", 32'(m_valid), 32'd0);
      check_eq("t5_rinc", 32'(rinc), 32'd0);
      check_eq("t5_out_cnt", 32'(out_cnt), 32'd0);
      check_eq("t5_flush_cnt", 32'(flush_cnt), 32'd0);
      fifo_q.delete();
      sb.delete();
      @(posedge rclk); #1;
      r_rst = 1'b0;

      // 6: out_cnt wraps after 2^CW transfers
      load(8'h10, 15);
      drain("t6a");
      check_eq("t6_out_15", 32'(out_cnt), 32'd15);
      load(8'h40, 1);
      drain("t6b");
      check_eq("t6_out_wrap", 32'(out_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
